instr_encode_writer: RTL and testbench

//  Inverse of the CPU instruction decode path: accepts instruction fields, packs them into 32-bit

---
 rtl/instr_encode_writer_if.sv | 44 ++++
 rtl/instr_encode_writer.sv | 158 +++++++++++++++
 tb/tb_instr_encode_writer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_writer_if.sv
// Field-input and memory-write bus bundle for instr_encode_writer.
// The master side supplies instruction fields and acknowledges bus writes. The slave side is the encoder/writer.
interface instr_encode_writer_if #(
   parameter int ADDR_W = 27,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_fmt;
   logic [3:0]        in_op;
   logic              in_ce;
   logic [3:0]        in_opcode;
   logic [10:0]       in_const11;
   logic [15:0]       in_const16;
   logic [26:0]       in_const27;
   logic              in_flag0;
   logic [3:0]        in_areg;
   logic [3:0]        in_breg;
   logic [3:0]        in_dreg;
   logic [31:0]       in_raw;
   logic              base_load;
   logic [ADDR_W-1:0] base_addr;
   logic              bus_start;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_data;
   logic              bus_we;
   logic              bus_done;
   logic              busy;
   logic [CNT_W-1:0]  words_written;

   modport master (
      output in_valid, in_fmt, in_op, in_ce, in_opcode, in_const11, in_const16,
             in_const27, in_flag0, in_areg, in_breg, in_dreg, in_raw,
             base_load, base_addr, bus_done,
      input  in_ready, bus_start, bus_addr, bus_data, bus_we, busy, words_written
   );

   modport slave (
      input  in_valid, in_fmt, in_op, in_ce, in_opcode, in_const11, in_const16,
             in_const27, in_flag0, in_areg, in_breg, in_dreg, in_raw,
             base_load, base_addr, bus_done,
      output in_ready, bus_start, bus_addr, bus_data, bus_we, busy, words_written
   );
endinterface

// File: rtl/instr_encode_writer.sv
// Packs instruction fields into 32-bit CPU words, queues them in a small FIFO and
// writes them to consecutive word addresses over the start/done bus.
module instr_encode_writer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 27,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_encode_writer_if.slave bus
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

   function automatic logic [31:0] encode_word(
      input logic [1:0]  fmt,
      input logic [3:0]  op,
      input logic        ce,
      input logic [3:0]  opcode,
      input logic [10:0] c11,
      input logic [15:0] c16,
      input logic [26:0] c27,
      input logic        flag0,
      input logic [3:0]  areg,
      input logic [3:0]  breg,
      input logic [3:0]  dreg,
      input logic [31:0] raw
   );
      logic [31:0] w;
      case (fmt)
         2'd0:    w = {op, ce, opcode, c11, areg, breg, dreg};
         2'd1:    w = {op, c16, areg, breg, dreg};
         2'd2:    w = {op, c27, flag0};
         2'd3:    w = raw;
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [31:0]       mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [PTR_W:0]    count_r, count_nxt_s;
   logic [31:0]       enc_s;
   logic              push_s, pop_s, idle_load_s;
   logic              start_nxt_s, busy_nxt_s, load_head_s;
   logic              in_ready_r, bus_start_r, busy_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       data_r;
   logic [CNT_W-1:0]  words_r;

   assign enc_s = encode_word(bus.in_fmt, bus.in_op, bus.in_ce, bus.in_opcode, bus.in_const11,
                              bus.in_const16, bus.in_const27, bus.in_flag0, bus.in_areg,
                              bus.in_breg, bus.in_dreg, bus.in_raw);

   // No bypass: a full FIFO refuses input even if the head pops this cycle.
   assign push_s      = bus.in_valid && in_ready_r;
   assign pop_s       = ((state_r == ST_REQ) || (state_r == ST_WAIT)) && bus.bus_done;
   assign idle_load_s = (state_r == ST_IDLE) && bus.base_load;

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + (PTR_W+1)'(1'b1);
      end else if (!push_s && pop_s) begin
         count_nxt_s = count_r - (PTR_W+1)'(1'b1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (count_r != '0) state_nxt_s = ST_REQ;
            else               state_nxt_s = ST_IDLE;
         end
         ST_REQ: begin
            if (bus.bus_done) state_nxt_s = ST_IDLE;
            else              state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.bus_done) state_nxt_s = ST_IDLE;
            else              state_nxt_s = ST_WAIT;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs, computed one cycle early so the bus pins come straight from flops
   always_comb begin
      start_nxt_s = 1'b0;
      busy_nxt_s  = 1'b0;
      load_head_s = 1'b0;
      start_nxt_s = (state_nxt_s == ST_REQ);
      busy_nxt_s  = (state_nxt_s != ST_IDLE) || (count_nxt_s != '0);
      load_head_s = (state_r == ST_IDLE) && (state_nxt_s == ST_REQ);
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= enc_s;
   end

   // FIFO pointers, write address, counter and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         bus_start_r <= 1'b0;
         busy_r      <= 1'b0;
         addr_r      <= '0;
         data_r      <= 32'd0;
         words_r     <= '0;
      end else begin
         count_r     <= count_nxt_s;
         in_ready_r  <= (count_nxt_s != FULL_CNT);
         bus_start_r <= start_nxt_s;
         busy_r      <= busy_nxt_s;
         if (push_s)      wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         if (pop_s)       rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         if (load_head_s) data_r   <= mem_r[rd_ptr_r];
         // A load in IDLE lands before the next REQ, so that write uses the new base.
         if (idle_load_s) begin
            addr_r  <= bus.base_addr;
            words_r <= '0;
         end else if (pop_s) begin
            addr_r <= addr_r + ADDR_W'(1'b1);
            if (words_r != CNT_MAX) words_r <= words_r + CNT_W'(1'b1);
         end
      end
   end

   assign bus.in_ready      = in_ready_r;
   assign bus.bus_start     = bus_start_r;
   assign bus.bus_we        = bus_start_r;
   assign bus.bus_addr      = addr_r;
   assign bus.bus_data      = data_r;
   assign bus.busy          = busy_r;
   assign bus.words_written = words_r;
endmodule

// File: tb/tb_instr_encode_writer.sv
// Scoreboard bench for instr_encode_writer: expected {addr,data} pairs are queued at push time
// and compared when the writer issues each bus transaction.
module tb_instr_encode_writer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   instr_encode_writer_if #(.ADDR_W(27), .CNT_W(16)) bus ();
   instr_encode_writer #(.DEPTH(4), .ADDR_W(27), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

   int          checks = 0;
   int          failures = 0;
   logic [58:0] sb_q [$];
   logic [26:0] model_addr = 27'd0;
   logic [15:0] model_cnt = 16'd0;
   int          start_cnt = 0;
   int          served_cnt = 0;

   // Count every bus_start cycle, sampled mid-cycle
   always @(negedge clk) if (bus.bus_start === 1'b1) start_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;   bus.in_fmt = 2'd0;      bus.in_op = 4'd0;
      bus.in_ce = 1'b0;      bus.in_opcode = 4'd0;   bus.in_const11 = 11'd0;
      bus.in_const16 = 16'd0; bus.in_const27 = 27'd0; bus.in_flag0 = 1'b0;
      bus.in_areg = 4'd0;    bus.in_breg = 4'd0;     bus.in_dreg = 4'd0;
      bus.in_raw = 32'd0;    bus.base_load = 1'b0;   bus.base_addr = 27'd0;
      bus.bus_done = 1'b0;
   endtask

   task automatic do_load(input logic [26:0] a);
      bus.base_addr = a;
      bus.base_load = 1'b1;
      tick();
      bus.base_load = 1'b0;
      model_addr = a;
      model_cnt = 16'd0;
   endtask

   // Drive one field set; every field is driven so unused ones must be ignored by the format
   task automatic push(input logic [1:0] fmt, input logic [3:0] op, input logic [26:0] cval,
                       input logic [11:0] regs, input logic bitv, input logic [3:0] opc,
                       input logic [31:0] raw, input logic [31:0] exp);
      int waited = 0;
      bus.in_fmt = fmt;  bus.in_op = op;  bus.in_ce = bitv;  bus.in_opcode = opc;
      bus.in_const11 = cval[10:0];  bus.in_const16 = cval[15:0];  bus.in_const27 = cval;
      bus.in_flag0 = bitv;  bus.in_areg = regs[11:8];  bus.in_breg = regs[7:4];
      bus.in_dreg = regs[3:0];  bus.in_raw = raw;  bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL push_ready got=%0b want=1", bus.in_ready);
      end else begin
         sb_q.push_back({model_addr, exp});
         model_addr = model_addr + 27'd1;
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Answer one bus transaction after 'delay' cycles; optionally pulse base_load while in WAIT
   task automatic serve(input int delay, input logic wait_load);
      int waited = 0;
      logic [58:0] exp;
      while (bus.bus_start !== 1'b1 && start_cnt <= served_cnt && waited < 40) begin
         tick();
         waited++;
      end
      checks++;
      if (bus.bus_start !== 1'b1 && start_cnt <= served_cnt) begin
         failures++;
         $display("FAIL serve_timeout got=no_bus_start want=bus_start");
      end else if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL serve_unexpected got=bus_write want=none");
      end else begin
         exp = sb_q.pop_front();
         checks += 2;
         if (bus.bus_addr !== exp[58:32]) begin
            failures++;
            $display("FAIL bus_addr got=%07h want=%07h", bus.bus_addr, exp[58:32]);
         end
         if (bus.bus_data !== exp[31:0]) begin
            failures++;
            $display("FAIL bus_data got=%08h want=%08h", bus.bus_data, exp[31:0]);
         end
         if (bus.bus_start === 1'b1) begin
            checks++;
            if (bus.bus_we !== 1'b1) begin
               failures++;
               $display("FAIL bus_we got=%0b want=1", bus.bus_we);
            end
         end
         if (wait_load) begin
            if (bus.bus_start === 1'b1) tick();
            bus.base_addr = 27'h55;
            bus.base_load = 1'b1;
            tick();
            bus.base_load = 1'b0;
         end
         repeat (delay) tick();
         bus.bus_done = 1'b1;
         tick();
         bus.bus_done = 1'b0;
         served_cnt++;
         model_cnt = model_cnt + 16'd1;
         checks += 3;
         if (bus.words_written !== model_cnt) begin
            failures++;
            $display("FAIL words_written got=%0d want=%0d", bus.words_written, model_cnt);
         end
         if (bus.bus_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_gap got=%0b want=0", bus.bus_start);
         end
         if (start_cnt != served_cnt) begin
            failures++;
            $display("FAIL start_pulses got=%0d want=%0d", start_cnt, served_cnt);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks += 3;
      if ({bus.in_ready, bus.busy, bus.bus_start, bus.bus_we} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_flags got=%04b want=1000",
                  {bus.in_ready, bus.busy, bus.bus_start, bus.bus_we});
      end
      if ({bus.bus_addr, bus.bus_data} !== 59'd0) begin
         failures++;
         $display("FAIL reset_bus got=%07h/%08h want=0/0", bus.bus_addr, bus.bus_data);
      end
      if (bus.words_written !== 16'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d want=0", bus.words_written);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_formats();
      do_load(27'h100);
      push(2'd0, 4'h0, 27'h7FF, 12'h123, 1'b1, 4'h5, 32'h13579BDF, 32'h0AFFF123);
      checks += 2;
      if ({bus.busy, bus.bus_start} !== 2'b10) begin
         failures++;
         $display("FAIL latency_n1 got=%02b want=10", {bus.busy, bus.bus_start});
      end
      tick();
      if (bus.bus_start !== 1'b1) begin
         failures++;
         $display("FAIL latency_n2 got=%0b want=1", bus.bus_start);
      end
      serve(2, 1'b0);
      push(2'd1, 4'h1, 27'h7FFBEEF, 12'h456, 1'b1, 4'hA, 32'h2468ACE0, 32'h1BEEF456);
      push(2'd2, 4'h9, 27'h1234567, 12'hABC, 1'b1, 4'h3, 32'h11111111, 32'h92468ACF);
      push(2'd3, 4'h7, 27'h5555, 12'hFFF, 1'b1, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF);
      serve(0, 1'b0);
      serve(1, 1'b0);
      serve(3, 1'b0);
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'hF00D0000 + i, 32'hF00D0000 + i);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready got=%0b want=0", bus.in_ready);
      end
      bus.in_raw = 32'h0BADBAD0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_hold got=%0b want=0", bus.in_ready);
      end
      serve(0, 1'b0);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_pop got=%0b want=1", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) serve(i, 1'b0);
      repeat (10) tick();
      checks += 2;
      if (start_cnt != served_cnt || sb_q.size() != 0) begin
         failures++;
         $display("FAIL overflow_word got=%0d want=%0d", start_cnt, served_cnt);
      end
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL drained_busy got=%0b want=0", bus.busy);
      end
   endtask

   task automatic test_wrap();
      do_load(27'h7FFFFFF);
      push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'hA5A5A5A5, 32'hA5A5A5A5);
      push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'h5A5A5A5A, 32'h5A5A5A5A);
      serve(1, 1'b0);
      serve(0, 1'b0);
      checks++;
      if (bus.words_written !== 16'd2) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=2", bus.words_written);
      end
   endtask

   task automatic test_load_in_wait();
      push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'h01234567, 32'h01234567);
      serve(1, 1'b1);
      push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'h89ABCDEF, 32'h89ABCDEF);
      serve(0, 1'b0);
      do_load(27'h200);
      checks += 2;
      if (bus.words_written !== 16'd0) begin
         failures++;
         $display("FAIL idle_load_count got=%0d want=0", bus.words_written);
      end
      if (bus.bus_addr !== 27'h200) begin
         failures++;
         $display("FAIL idle_load_addr got=%07h want=0000200", bus.bus_addr);
      end
   endtask

   task automatic test_reset_mid();
      int waited = 0;
      push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, 32'hCAFEF00D, 32'hCAFEF00D);
      while (bus.bus_start !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks += 2;
      if ({bus.busy, bus.bus_start, bus.in_ready} !== 3'b001) begin
         failures++;
         $display("FAIL reset_mid got=%03b want=001", {bus.busy, bus.bus_start, bus.in_ready});
      end
      sb_q.delete();
      model_addr = 27'd0;
      model_cnt = 16'd0;
      served_cnt = start_cnt;
      bus.bus_done = 1'b1;
      tick();
      bus.bus_done = 1'b0;
      repeat (5) tick();
      if (bus.words_written !== 16'd0 || start_cnt != served_cnt) begin
         failures++;
         $display("FAIL late_done got=%0d want=0", bus.words_written);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         push(2'd3, 4'd0, 27'd0, 12'd0, 1'b0, 4'd0, w, w);
      end
      for (int i = 0; i < 4; i++) serve($urandom_range(0, 2), 1'b0);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_formats();
      test_full();
      test_wrap();
      test_load_in_wait();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
